// File: rtl/intrusion_alarm_ctrl.sv
// intrusion_alarm_ctrl: debounced, tick-confirmed perimeter intrusion alarm controller
module intrusion_alarm_ctrl #(
  parameter int SENSOR_W      = 4,
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int CONFIRM_TICKS = 2,
  parameter int ALARM_TICKS   = 10
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                slow_clk,
  input  logic                arm,
  input  logic                ack,
  input  logic [SENSOR_W-1:0] sensor,
  output logic [1:0]          state,
  output logic [SENSOR_W-1:0] zone,
  output logic                armed_led,
  output logic                alarm,
  output logic                buzzer,
  output logic                alarm_led
);
  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int CW = $clog2(CONFIRM_TICKS) + 1;
  localparam int HW = $clog2(ALARM_TICKS + 1) + 1;
  localparam logic [1:0] S_DIS = 2'd0, S_ARM = 2'd1, S_PEN = 2'd2, S_ALM = 2'd3;
  logic s1, s2, s3, tick, active;
  logic [1:0] arm_q, ack_q;
  logic [SENSOR_W-1:0] sen1, sen2, db, zone_n;
  logic [1:0] st, st_n;
  logic [CW-1:0] conf, conf_n;
  logic [HW-1:0] hold, hold_n;
  // bring slow clock, arm, ack and sensors into the clk_in domain
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      {s3, s2, s1} <= '0;
      arm_q <= '0;
      ack_q <= '0;
      sen1 <= '0;
      sen2 <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, slow_clk};
      arm_q <= {arm_q[0], arm};
      ack_q <= {ack_q[0], ack};
      sen1 <= sensor;
      sen2 <= sen1;
    end
  assign tick = s2 & ~s3;
  assign active = |db;
  for (genvar i = 0; i < SENSOR_W; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic stable;
    // stable value flips only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
        cnt <= '0;
        stable <= 1'b0;
      end else if (sen2[i] == stable) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
        stable <= sen2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    assign db[i] = stable;
  end
  // state, zone and confirm/hold counters
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      st <= S_DIS;
      zone <= '0;
      conf <= '0;
      hold <= '0;
    end else begin
      st <= st_n;
      zone <= zone_n;
      conf <= conf_n;
      hold <= hold_n;
    end
  // next-state: disarm beats everything, then ack, then false alarm / hold expiry, then ticks
  always_comb begin
    st_n = st;
    zone_n = zone;
    conf_n = conf;
    hold_n = hold;
    case (st)
      S_DIS: st_n = arm_q[1] ? S_ARM : S_DIS;
      S_ARM:
        if (!arm_q[1]) st_n = S_DIS;
        else if (active) begin
          st_n = S_PEN;
          zone_n = db;
          conf_n = '0;
        end
      S_PEN:
        if (!arm_q[1]) begin
          st_n = S_DIS;
          zone_n = '0;
        end else if (!active) begin
          st_n = S_ARM;
          zone_n = '0;
        end else begin
          zone_n = zone | db;
          if (tick && conf == CW'(CONFIRM_TICKS - 1)) begin
            st_n = S_ALM;
            hold_n = '0;
          end else if (tick) conf_n = conf + CW'(1);
        end
      default:
        if (!arm_q[1]) begin
          st_n = S_DIS;
          zone_n = '0;
        end else if (ack_q[1] || (hold == HW'(ALARM_TICKS) && !active)) begin
          st_n = S_ARM;
          zone_n = '0;
        end else begin
          zone_n = zone | db;
          hold_n = (tick && hold != HW'(ALARM_TICKS)) ? hold + HW'(1) : hold;
        end
    endcase
  end
  // outputs decoded purely from registers
  always_comb begin
    state = st;
    armed_led = st != S_DIS;
    alarm = st == S_ALM;
    buzzer = st == S_ALM;
    alarm_led = (st == S_ALM) & s2;
  end
endmodule

// File: tb/tb_intrusion_alarm_ctrl.sv
// tb_intrusion_alarm_ctrl: randomized and directed check against a history-based reference model
module tb_intrusion_alarm_ctrl;
  localparam int SW = 4, DEB = 4, CONF = 2, HOLD = 3;
  logic clk_in = 0, rst = 1, slow_clk = 0, arm = 0, ack = 0;
  logic [SW-1:0] sensor = '0;
  logic [1:0] state;
  logic [SW-1:0] zone;
  logic armed_led, alarm, buzzer, alarm_led;
  int n_chk = 0, n_err = 0, tcnt = 0, tick_seen = 0, r, gl = 0, gb = 0;
  bit auto_slow = 1;
  int m_state, m_ticks, m_hold;
  logic [SW-1:0] m_zone, m_db;
  logic h_arm [8], h_ack [8], h_slow [8];
  logic [SW-1:0] h_sen [8];

  intrusion_alarm_ctrl #(.SENSOR_W(SW), .DEBOUNCE_CYC(DEB), .CONFIRM_TICKS(CONF), .ALARM_TICKS(HOLD)) dut (
    .clk_in(clk_in), .rst(rst), .slow_clk(slow_clk), .arm(arm), .ack(ack), .sensor(sensor),
    .state(state), .zone(zone), .armed_led(armed_led), .alarm(alarm), .buzzer(buzzer), .alarm_led(alarm_led)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_ticks = 0; m_hold = 0; m_zone = '0; m_db = '0;
    for (int j = 0; j < 8; j++) begin
      h_arm[j] = 0; h_ack[j] = 0; h_slow[j] = 0; h_sen[j] = '0;
    end
  endfunction

  // h_*[0] holds the input sampled at the newest edge; synced values are two edges old
  task automatic model_step();
    int ns, nt, nh;
    logic [SW-1:0] nz;
    logic a, k, tk, act, diff;
    if (rst) begin
      model_reset();
      return;
    end
    for (int j = 7; j > 0; j--) begin
      h_arm[j] = h_arm[j-1]; h_ack[j] = h_ack[j-1]; h_slow[j] = h_slow[j-1]; h_sen[j] = h_sen[j-1];
    end
    h_arm[0] = arm; h_ack[0] = ack; h_slow[0] = slow_clk; h_sen[0] = sensor;
    a = h_arm[2]; k = h_ack[2]; tk = h_slow[2] & !h_slow[3]; act = |m_db;
    ns = m_state; nz = m_zone; nt = m_ticks; nh = m_hold;
    if (m_state == 0) ns = a ? 1 : 0;
    else if (!a) begin ns = 0; nz = '0; end
    else if (m_state == 1) begin
      if (act) begin ns = 2; nz = m_db; nt = 0; end
    end else if (m_state == 2) begin
      if (!act) begin ns = 1; nz = '0; end
      else begin
        nz = m_zone | m_db;
        if (tk) begin
          nt = m_ticks + 1;
          if (nt == CONF) begin ns = 3; nh = 0; end
        end
      end
    end else begin
      if (k || (m_hold == HOLD && !act)) begin ns = 1; nz = '0; end
      else begin
        nz = m_zone | m_db;
        if (tk && m_hold < HOLD) nh = m_hold + 1;
      end
    end
    for (int b = 0; b < SW; b++) begin
      diff = 1;
      for (int d = 0; d < DEB; d++) if (h_sen[2+d][b] == m_db[b]) diff = 0;
      if (diff) m_db[b] = !m_db[b];
    end
    m_state = ns; m_zone = nz; m_ticks = nt; m_hold = nh;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    chk("state", state, m_state);
    chk("zone", zone, m_zone);
    chk("armed_led", armed_led, m_state != 0);
    chk("alarm", alarm, m_state == 3);
    chk("buzzer", buzzer, m_state == 3);
    chk("alarm_led", alarm_led, m_state == 3 && h_slow[1]);
    chk("tick", dut.tick, h_slow[1] & !h_slow[2]);
    if (dut.tick) tick_seen++;
    if (auto_slow) begin
      slow_clk = (tcnt / 20) % 2 == 1;
      tcnt++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_for(input string tag, input int st, input int lim);
    int n = 0;
    while (state != 2'(st) && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, state, st);
  endtask

  initial begin
    model_reset();
    run(3);
    rst = 0;
    run(2);
    arm = 1;
    run(6);
    chk("armed", state, 1);
    sensor[2] = 1; run(3); sensor[2] = 0; run(8);
    chk("glitch_ignored", state, 1);
    sensor[2] = 1; run(10);
    chk("pend_state", state, 2);
    chk("pend_zone", zone, 4'b0100);
    sensor = '0; run(20);
    chk("false_alarm_state", state, 1);
    chk("false_alarm_zone", zone, 0);
    sensor = 4'b0001;
    wait_for("reach_alarm", 3, 200);
    chk("alarm_buzzer", buzzer, 1);
    sensor[3] = 1; run(10);
    chk("alarm_zone", zone, 4'b1001);
    run(130);
    chk("hold_while_active", state, 3);
    sensor = '0;
    wait_for("hold_expiry", 1, 200);
    sensor = 4'b0010;
    wait_for("reach_alarm2", 3, 200);
    ack = 1; run(1); ack = 0;
    wait_for("ack_exit", 1, 10);
    wait_for("reach_alarm3", 3, 200);
    arm = 0; ack = 1; run(1); ack = 0;
    wait_for("disarm_over_ack", 0, 10);
    arm = 1; sensor = '0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (gl > 0) begin
        gl--;
        if (gl == 0) sensor[gb] = ~sensor[gb];
      end else if (r < 6) begin
        gb = $urandom_range(0, SW - 1);
        sensor[gb] = ~sensor[gb];
      end else if (r < 9) begin
        gb = $urandom_range(0, SW - 1);
        sensor[gb] = ~sensor[gb];
        gl = $urandom_range(1, 3);
      end
      ack = (r == 10 || r == 11);
      if (r == 12) arm = 0;
      else if (!arm && r < 40) arm = 1;
      cyc();
    end
    arm = 1; ack = 0; gl = 0; sensor = 4'b0001;
    wait_for("reach_alarm4", 3, 300);
    #2 rst = 1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_buzzer", buzzer, 0);
    chk("async_rst_zone", zone, 0);
    model_reset();
    run(2);
    rst = 0;
    run(2);
    chk("rearm_early", state, 0);
    run(1);
    chk("rearm_latency", state, 1);
    auto_slow = 0;
    slow_clk = 1; run(10);
    tick_seen = 0;
    slow_clk = 0; run(10);
    chk("fall_no_tick", tick_seen, 0);
    slow_clk = 1; run(10);
    chk("rise_one_tick", tick_seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/intrusion_alarm_ctrl.md
Name: intrusion_alarm_ctrl

Overview:
Downstream consumer of the divided slow clock in the border intrusion system. The slow clock is not used as a clock. It is sampled in the clk_in domain and edge-detected into a one-cycle time-base tick. The block debounces the perimeter sensor inputs and confirms an intrusion over a number of ticks before raising the alarm. It then drives the buzzer and a blinking alarm LED until the operator acknowledges, disarms, or the hold time expires.

Parameters:
SENSOR_W, 4, number of sensor zones.
DEBOUNCE_CYC, 1_000_000, consecutive clk_in cycles an input must differ from its stable value before the stable value changes.
CONFIRM_TICKS, 2, ticks a detection must persist in PENDING before ALARM (≥1).
ALARM_TICKS, 10, minimum ticks ALARM holds before auto-return (≥1).

Ports:
clk_in  input  1  system clock; the only clock.
rst  input  1  asynchronous, active-high reset.
slow_clk  input  1  divided clock from the clock divider, treated as data.
arm  input  1  level; 1 = system armed (asynchronous, 2FF-synced).
ack  input  1  level; operator acknowledge (asynchronous, 2FF-synced).
sensor  input  SENSOR_W  raw intrusion sensors, 1 = intrusion (asynchronous).
state  output  2  0 DISARMED, 1 ARMED, 2 PENDING, 3 ALARM.
zone  output  SENSOR_W  latched zones that triggered the current event.
armed_led  output  1  1 when state != DISARMED.
alarm  output  1  1 in ALARM.
buzzer  output  1  1 in ALARM.
alarm_led  output  1  in ALARM equals synced slow_clk; otherwise 0.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - state = DISARMED; zone = 0; all LEDs, alarm and buzzer = 0.
  - All synchronizers, debounce counters, confirm and hold counters = 0.
- Tick generation: s1 <= slow_clk; s2 <= s1; s3 <= s2; tick = s2 & ~s3.
  - If slow_clk rises before clk_in edge E1, tick is high for exactly the one cycle between E2 and E3.
  - Falling edges produce no tick.
- arm, ack and each sensor bit pass through a 2FF synchronizer.
- Debounce, per sensor bit:
  - The counter clears while the synced input equals the stable value.
  - The counter increments while they differ.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, the stable value flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no change.
  - Counter width = clog2(DEBOUNCE_CYC)+1.
- active = OR of the debounced sensor bits.
- FSM, one transition per cycle; arm/ack below mean their synced values:
  - DISARMED: arm=1 -> ARMED.
  - ARMED:
    - arm=0 -> DISARMED.
    - else active -> PENDING; zone <= debounced; confirm_cnt <= 0.
  - PENDING, priority order:
    - arm=0 -> DISARMED, zone <= 0.
    - else !active -> ARMED, zone <= 0 (false alarm). This wins over a simultaneous tick.
    - else on tick: if confirm_cnt == CONFIRM_TICKS-1 -> ALARM with hold_cnt <= 0; otherwise confirm_cnt++.
    - zone |= debounced every cycle while in PENDING.
  - ALARM, priority order:
    - arm=0 -> DISARMED, zone <= 0.
    - else ack=1 -> ARMED, zone <= 0.
    - else if hold_cnt == ALARM_TICKS and !active -> ARMED, zone <= 0.
    - else on tick: hold_cnt++, saturating at ALARM_TICKS.
    - zone |= debounced while in ALARM.
  - ack is ignored outside ALARM. If ack is held into ALARM entry, ALARM exits on the next cycle.
- Outputs:
  - All outputs are decoded from registered state or registers only; there is no combinational path from inputs.
  - Outputs are valid the cycle after the state update.

Test Plan:
- Bench parameters: DEBOUNCE_CYC=4, CONFIRM_TICKS=2, ALARM_TICKS=3; slow_clk driven by the bench with a 40-cycle period.
- Reset: assert rst mid-ALARM, asynchronously between edges -> state=0, buzzer=0, zone=0 immediately; after release and arm=1 -> state=1 at sync latency + 1 cycle.
- Debounce: pulse sensor[2] for 3 cycles -> stays ARMED; hold for 4+ cycles -> PENDING, zone=4'b0100.
- Confirm: hold sensor[0] active -> ALARM on the 2nd tick after PENDING entry; buzzer=1; alarm_led tracks s2 (20 cycles high, 20 low); sensor[3] rising during ALARM -> zone=4'b1001.
- False alarm: sensor drops (debounced) before the 2nd tick -> ARMED, zone=0; drop coinciding with a tick -> ARMED, not ALARM.
- Hold/ack:
  - Release sensors in ALARM -> ARMED after the 3rd tick.
  - Sensors still active at 3 ticks -> stays ALARM until inactive.
  - ack pulse at any time in ALARM -> ARMED.
  - arm=0 together with ack -> DISARMED.
- Tick edge: slow_clk falling edge only -> no tick; a single slow_clk rise -> exactly one cycle of tick.
